instruction_fetch: RTL and testbench

Fetch stage directly downstream of `program_counter`. Issues one instruction-memory read per PC value and drives the counter's `latch` to advance it. Buffers returned 64-bit instructions with their PC in a small FIFO and presents them to decode over a valid/ready handshake. Branch redirects flush all buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instruction_fetch.sv | 109 ++++++++++
 tb/tb_instruction_fetch.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Provides width defaults and the fetch FSM state enum.
package fetch_pkg;

  localparam int DEF_PC_W    = 32;
  localparam int DEF_INSTR_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs for decode.
// Ports: clk, rst (async low), clear, push/push_data, pop, valid, head, count.
module fetch_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop & (cnt != '0);
  assign do_push = push & ((cnt != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Head is read straight from registered storage.
  assign head  = mem[rd_ptr];
  assign valid = cnt != '0;
  assign count = cnt;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, FIFO to decode, flush on branch.
// Ports: pc/pc_latch to counter, imem_req/rsp to memory, instr_* to decode.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic [PC_W-1:0]    pc,
  input  logic               flush,
  output logic               pc_latch,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int EW = PC_W + INSTR_W;

  state_t          state;
  state_t          state_d;
  logic [PC_W-1:0] req_pc_q;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   need;
  logic [SW-1:0]   room;
  logic [EW-1:0]   head;
  logic            pop;
  logic            push;
  logic            hs;
  logic            credit;
  logic            outstanding;

  assign pop         = instr_valid & instr_ready;
  assign outstanding = state == WAIT;

  // cnt + outstanding - pop < DEPTH, rearranged to avoid underflow.
  assign need   = SW'(cnt) + SW'(outstanding);
  assign room   = SW'(DEPTH) + SW'(pop);
  assign credit = need < room;

  assign imem_req_valid = fetch_en & ~flush & credit &
                          ((state == IDLE) |
                           ((state == WAIT) & imem_rsp_valid));
  assign imem_req_addr  = pc;
  assign hs             = imem_req_valid & imem_req_ready;
  // Flush also latches so the counter loads the branch target.
  assign pc_latch       = hs | flush;
  assign push           = (state == WAIT) & imem_rsp_valid & ~flush;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (hs) state_d = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_d = imem_rsp_valid ? IDLE : DISCARD;
        end else if (imem_rsp_valid) begin
          state_d = hs ? WAIT : IDLE;
        end
      end
      DISCARD: begin
        if (flush | imem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req_pc_q <= '0;
    end else begin
      state <= state_d;
      if (hs) req_pc_q <= pc;
    end
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data ({req_pc_q, imem_rsp_data}),
    .pop       (pop),
    .valid     (instr_valid),
    .head      (head),
    .count     (cnt)
  );

  assign instr_pc   = head[EW-1:INSTR_W];
  assign instr_data = head[INSTR_W-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: program counter and memory models,
// stream scoreboard plus directed literal expectations.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] pc;
  logic        flush;
  logic        pc_latch;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [63:0] instr_data;
  logic [31:0] instr_pc;

  int          checks = 0;
  int          failures = 0;

  int          mem_lat = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;
  logic [31:0] target = '0;
  logic [31:0] saved;

  logic [31:0] exp_q [$];
  int          outs = 0;
  logic        fl_prev = 1'b0;

  instruction_fetch #(
    .PC_W    (32),
    .INSTR_W (64),
    .DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .pc             (pc),
    .flush          (flush),
    .pc_latch       (pc_latch),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Counter and memory models: sample mid-cycle, apply after the edge.
  task automatic tick();
    logic        s_hs;
    logic        s_lat;
    logic        s_fl;
    logic        s_rsp;
    logic [31:0] s_pc;
    @(negedge clk);
    s_hs  = imem_req_valid & imem_req_ready;
    s_lat = pc_latch;
    s_fl  = flush;
    s_rsp = imem_rsp_valid;
    s_pc  = pc;
    @(posedge clk);
    #1;
    if (s_lat) pc = s_fl ? target : pc + 32'd8;
    if (s_rsp) pend = 1'b0;
    if (s_hs) begin
      pend      = 1'b1;
      pend_addr = s_pc;
      pend_wait = mem_lat;
    end
    imem_rsp_valid = 1'b0;
    if (pend) begin
      pend_wait--;
      if (pend_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(pend_addr);
      end
    end
    #1;
  endtask

  task automatic chk_reset_vals();
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr_pc", 64'(instr_pc), 64'h0);
    chk("rst_instr_data", instr_data, 64'h0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_pc_latch", pc_latch, 1'b0);
  endtask

  // Stream model: delivered = accepted requests in order, minus flushed.
  always @(negedge clk) begin : cmp
    logic hs_n;
    if (!rst) begin
      exp_q.delete();
      outs    = 0;
      fl_prev = 1'b0;
    end else begin
      hs_n = imem_req_valid & imem_req_ready;
      chk1("pc_latch", pc_latch, hs_n | flush);
      if (imem_req_valid) begin
        chk("req_addr", 64'(imem_req_addr), 64'(pc));
        chk1("one_outstanding", (outs == 0) || imem_rsp_valid, 1'b1);
      end
      if (fl_prev) chk1("valid_after_flush", instr_valid, 1'b0);
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_instr got_pc=%h exp=none", instr_pc);
        end else begin
          chk("stream_pc", 64'(instr_pc), 64'(exp_q[0]));
          chk("stream_data", instr_data, word(exp_q[0]));
          if (instr_ready && !flush) void'(exp_q.pop_front());
        end
      end
      outs += int'(hs_n);
      outs -= int'(imem_rsp_valid);
      if (flush) exp_q.delete();
      if (hs_n) exp_q.push_back(pc);
      fl_prev = flush;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    fetch_en       = 1'b0;
    flush          = 1'b0;
    pc             = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    #2;
    chk_reset_vals();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk1("idle_no_req", imem_req_valid, 1'b0);

    // Streaming with 1-cycle memory.
    fetch_en       = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    #1;
    chk1("t1_req", imem_req_valid, 1'b1);
    chk("t1_addr0", 64'(imem_req_addr), 64'h0);
    tick();
    chk1("t1_not_yet", instr_valid, 1'b0);
    chk("t1_addr8", 64'(imem_req_addr), 64'h8);
    tick();
    chk1("t1_valid", instr_valid, 1'b1);
    chk("t1_pc0", 64'(instr_pc), 64'h0);
    chk("t1_data0", instr_data, 64'hFFFFFFFF_00000000);
    tick();
    chk("t1_pc8", 64'(instr_pc), 64'h8);
    chk("t1_data8", instr_data, 64'hFFFFFFF7_00000008);
    tick();
    chk("t1_pc16", 64'(instr_pc), 64'h10);

    // Backpressure: buffer fills, issue stops.
    instr_ready = 1'b0;
    #1;
    chk1("t2_no_req", imem_req_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("t2_hold_req", imem_req_valid, 1'b0);
      chk1("t2_hold_latch", pc_latch, 1'b0);
      chk("t2_hold_pc", 64'(instr_pc), 64'h10);
    end
    instr_ready = 1'b1;
    #1;
    chk1("t2_resume", imem_req_valid, 1'b1);
    chk("t2_resume_addr", 64'(imem_req_addr), 64'h20);
    tick();
    chk("t2_pc24", 64'(instr_pc), 64'h18);
    tick();
    chk("t2_pc32", 64'(instr_pc), 64'h20);

    // Flush with a slow response outstanding.
    fetch_en = 1'b0;
    repeat (6) tick();
    chk1("t3_drained", instr_valid, 1'b0);
    mem_lat  = 4;
    fetch_en = 1'b1;
    #1;
    chk1("t3_req", imem_req_valid, 1'b1);
    tick();
    flush  = 1'b1;
    target = 32'h100;
    #1;
    chk1("t3_flush_latch", pc_latch, 1'b1);
    tick();
    flush   = 1'b0;
    mem_lat = 1;
    #1;
    chk1("t3_discard_no_req", imem_req_valid, 1'b0);
    for (int i = 0; i < 12 && !instr_valid; i++) tick();
    chk1("t3_valid", instr_valid, 1'b1);
    chk("t3_pc100", 64'(instr_pc), 64'h100);

    // Flush together with a response and a pop.
    flush  = 1'b1;
    target = 32'h200;
    #1;
    chk1("t4_flush_latch", pc_latch, 1'b1);
    tick();
    flush = 1'b0;
    #1;
    chk1("t4_empty", instr_valid, 1'b0);
    chk1("t4_req", imem_req_valid, 1'b1);
    chk("t4_target", 64'(imem_req_addr), 64'h200);
    tick();
    tick();
    chk1("t4_valid", instr_valid, 1'b1);
    chk("t4_pc200", 64'(instr_pc), 64'h200);

    // Memory not ready: pc must hold.
    imem_req_ready = 1'b0;
    #1;
    saved = pc;
    for (int i = 0; i < 3; i++) begin
      chk1("t5_no_latch", pc_latch, 1'b0);
      tick();
      chk("t5_pc_hold", 64'(pc), 64'(saved));
    end
    imem_req_ready = 1'b1;
    #1;
    chk1("t5_req", imem_req_valid, 1'b1);
    chk1("t5_latch", pc_latch, 1'b1);
    chk("t5_addr", 64'(imem_req_addr), 64'(saved));

    // Reset mid-stream with the buffer full.
    instr_ready = 1'b0;
    repeat (4) tick();
    chk1("t6_full_no_req", imem_req_valid, 1'b0);
    chk1("t6_buffered", instr_valid, 1'b1);
    fetch_en = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    pend           = 1'b0;
    imem_rsp_valid = 1'b0;
    tick();
    rst         = 1'b1;
    saved       = pc;
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk1("t6_restart", imem_req_valid, 1'b1);
    chk("t6_restart_addr", 64'(imem_req_addr), 64'(saved));
    tick();
    tick();
    chk("t6_first_pc", 64'(instr_pc), 64'(saved));
    repeat (4) tick();

    fetch_en = 1'b0;
    repeat (6) tick();
    chk("final_drained", 64'(exp_q.size()), 64'h0);
    chk1("final_idle", instr_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
